// File: rtl/joint_cmd_guard.sv
// Guards the signed joint period command: minimum period, speed-up rate limit,
// zero-hold on direction reversal and host-loss watchdog.
module joint_cmd_guard #(
   parameter int UPDATE_DIV   = 48000,
   parameter int MIN_PERIOD   = 100,
   parameter int START_PERIOD = 48000,
   parameter int MAX_DELTA    = 1000,
   parameter int WDT_TICKS    = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cmdIn,
   input  logic        cmdLoad,
   input  logic        enable,
   output logic [31:0] jointFreqCmd,
   output logic        timeout,
   output logic        ramping
);

   localparam int CW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
   localparam int WW = $clog2(WDT_TICKS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(UPDATE_DIV - 1);
   localparam logic [WW-1:0] WDT_MAX  = WW'(WDT_TICKS);
   localparam logic [WW-1:0] WDT_LAST = WW'(WDT_TICKS - 1);
   localparam logic [31:0]   MIN_P    = 32'(MIN_PERIOD);
   localparam logic [31:0]   START_P  = 32'(START_PERIOD);
   localparam logic [31:0]   DELTA_P  = 32'(MAX_DELTA);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_REVERSE = 2'd2;
   localparam logic [1:0] ST_FAULT   = 2'd3;

   logic [CW-1:0]      cnt_p0;
   logic [WW-1:0]      wdt_p0;
   logic signed [31:0] target_p0;
   logic signed [31:0] out_p0;
   logic [1:0]         state_p0;
   logic               timeout_p0;
   logic               ramping_p0;

   logic               tick;
   logic               wdt_expire;
   logic [1:0]         state_n;
   logic signed [31:0] out_n;
   logic               tmo_n;
   logic               ramp_n;
   logic [31:0]        tgt_mag;
   logic [31:0]        out_mag;
   logic [31:0]        floor_mag;

   function automatic logic [31:0] mag(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [31:0] apply_sign(input logic neg, input logic [31:0] m);
      return neg ? (~m + 32'd1) : m;
   endfunction

   function automatic logic [31:0] umax(input logic [31:0] a, input logic [31:0] b);
      return (a > b) ? a : b;
   endfunction

   // Most-negative value has no positive twin, so it is pulled in by one.
   function automatic logic [31:0] sat_clamp(input logic [31:0] c);
      if (c == 32'h8000_0000)
         return 32'h8000_0001;
      if ((c != 32'd0) && (mag(c) < MIN_P))
         return apply_sign(c[31], MIN_P);
      return c;
   endfunction

   assign tick       = (cnt_p0 == CNT_LAST);
   assign wdt_expire = tick && !cmdLoad && (wdt_p0 >= WDT_LAST);

   always_comb begin
      state_n   = state_p0;
      out_n     = out_p0;
      tmo_n     = timeout_p0;
      ramp_n    = ramping_p0;
      tgt_mag   = mag(target_p0);
      out_mag   = mag(out_p0);
      floor_mag = umax(tgt_mag, MIN_P);
      if (state_p0 == ST_FAULT) begin
         if (cmdLoad && (cmdIn == 32'd0)) begin
            state_n = ST_IDLE;
            tmo_n   = 1'b0;
         end
      end else if (wdt_expire) begin
         state_n = ST_FAULT;
         out_n   = '0;
         tmo_n   = 1'b1;
         ramp_n  = 1'b0;
      end else if (!enable) begin
         state_n = ST_IDLE;
         out_n   = '0;
         ramp_n  = 1'b0;
      end else if (tick) begin
         case (state_p0)
            ST_IDLE: begin
               if (target_p0 != 32'sd0) begin
                  out_n   = apply_sign(target_p0[31], umax(tgt_mag, START_P));
                  state_n = ST_RUN;
               end else begin
                  out_n = '0;
               end
            end
            ST_RUN: begin
               if (target_p0 == 32'sd0) begin
                  out_n   = '0;
                  state_n = ST_IDLE;
               end else if (target_p0[31] != out_p0[31]) begin
                  out_n   = '0;
                  state_n = ST_REVERSE;
               end else if (tgt_mag >= out_mag) begin
                  out_n = target_p0;
               end else if ((out_mag - floor_mag) > DELTA_P) begin
                  // Difference test first so the subtraction can never wrap.
                  out_n = apply_sign(out_p0[31], out_mag - DELTA_P);
               end else begin
                  out_n = apply_sign(out_p0[31], floor_mag);
               end
            end
            default: begin
               out_n   = '0;
               state_n = ST_IDLE;
            end
         endcase
         ramp_n = (state_n == ST_RUN) && (mag(out_n) != tgt_mag);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_p0     <= '0;
         wdt_p0     <= '0;
         target_p0  <= '0;
         out_p0     <= '0;
         state_p0   <= ST_IDLE;
         timeout_p0 <= 1'b0;
         ramping_p0 <= 1'b0;
      end else begin
         cnt_p0     <= tick ? '0 : cnt_p0 + 1'b1;
         state_p0   <= state_n;
         out_p0     <= out_n;
         timeout_p0 <= tmo_n;
         ramping_p0 <= ramp_n;
         if (cmdLoad)
            target_p0 <= sat_clamp(cmdIn);
         if (cmdLoad)
            wdt_p0 <= '0;
         else if (tick && (wdt_p0 != WDT_MAX))
            wdt_p0 <= wdt_p0 + 1'b1;
      end
   end

   assign jointFreqCmd = out_p0;
   assign timeout      = timeout_p0;
   assign ramping      = ramping_p0;

endmodule

// File: tb/tb_joint_cmd_guard.sv
// Bench for joint_cmd_guard with scaled-down timing parameters, directed
// scenarios plus a randomized run against a behavioural model.
module tb_joint_cmd_guard;

   localparam int UD    = 16;
   localparam int MINP  = 10;
   localparam int START = 500;
   localparam int DELTA = 100;
   localparam int WDT   = 12;

   localparam int S_IDLE  = 0;
   localparam int S_RUN   = 1;
   localparam int S_REV   = 2;
   localparam int S_FAULT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cmdIn;
   logic        cmdLoad;
   logic        enable;
   logic [31:0] jointFreqCmd;
   logic        timeout;
   logic        ramping;

   int checks   = 0;
   int failures = 0;

   int     m_cnt;
   int     m_quiet;
   int     m_st;
   longint m_tgt;
   longint m_out;
   bit     m_tmo;
   bit     m_ramp;
   bit     m_ticked;

   joint_cmd_guard #(
      .UPDATE_DIV(UD), .MIN_PERIOD(MINP), .START_PERIOD(START),
      .MAX_DELTA(DELTA), .WDT_TICKS(WDT)
   ) dut (
      .clk(clk), .reset(reset), .cmdIn(cmdIn), .cmdLoad(cmdLoad), .enable(enable),
      .jointFreqCmd(jointFreqCmd), .timeout(timeout), .ramping(ramping)
   );

   always #5 clk = ~clk;

   function automatic longint labs(input longint v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic longint sgn(input longint v);
      return (v > 0) ? 64'sd1 : ((v < 0) ? -64'sd1 : 64'sd0);
   endfunction

   function automatic longint lmax(input longint a, input longint b);
      return (a > b) ? a : b;
   endfunction

   function automatic longint load_value(input longint c);
      if (c == -64'sd2147483648) return -64'sd2147483647;
      if (c != 0 && labs(c) < MINP) return sgn(c) * MINP;
      return c;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_quiet = 0; m_st = S_IDLE; m_tgt = 0; m_out = 0;
      m_tmo = 0; m_ramp = 0; m_ticked = 0;
   endtask

   task automatic model_update();
      bit     tk;
      longint t;
      longint o;
      tk = (m_cnt == UD - 1);
      m_ticked = tk;
      t = m_tgt;
      o = m_out;
      m_cnt = tk ? 0 : m_cnt + 1;
      if (m_st == S_FAULT) begin
         if (cmdLoad && cmdIn == 32'd0) begin m_st = S_IDLE; m_tmo = 0; end
      end else if (tk && !cmdLoad && m_quiet + 1 >= WDT) begin
         m_st = S_FAULT; m_out = 0; m_tmo = 1; m_ramp = 0;
      end else if (!enable) begin
         m_st = S_IDLE; m_out = 0; m_ramp = 0;
      end else if (tk) begin
         case (m_st)
            S_IDLE: begin
               if (t != 0) begin m_out = sgn(t) * lmax(labs(t), START); m_st = S_RUN; end
               else m_out = 0;
            end
            S_RUN: begin
               if (t == 0) begin m_out = 0; m_st = S_IDLE; end
               else if (sgn(t) != sgn(o)) begin m_out = 0; m_st = S_REV; end
               else if (labs(t) >= labs(o)) m_out = t;
               else m_out = sgn(o) * lmax(lmax(labs(t), MINP), labs(o) - DELTA);
            end
            default: begin m_out = 0; m_st = S_IDLE; end
         endcase
         m_ramp = (m_st == S_RUN) && (labs(m_out) != labs(t));
      end
      if (cmdLoad) m_quiet = 0;
      else if (tk && m_quiet < WDT) m_quiet++;
      if (cmdLoad) m_tgt = load_value(longint'($signed(cmdIn)));
   endtask

   task automatic step();
      @(negedge clk);
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] v);
      cmdIn = v;
      cmdLoad = 1'b1;
      step();
      cmdLoad = 1'b0;
   endtask

   task automatic wait_ticks(input int n);
      int seen = 0;
      while (seen < n) begin
         step();
         if (m_ticked) seen++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (jointFreqCmd !== 32'd0 || timeout !== 1'b0 || ramping !== 1'b0) begin
         failures++;
         $display("FAIL reset: out=%0d timeout=%0b ramping=%0b, want 0/0/0",
                  $signed(jointFreqCmd), timeout, ramping);
      end
   endtask

   task automatic test_basic();
      do_reset();
      enable = 1'b1;
      load(32'd1000);
      wait_ticks(2);
      checks++;
      if ($signed(jointFreqCmd) !== 32'sd1000 || ramping !== 1'b0) begin
         failures++;
         $display("FAIL basic_load: out=%0d ramping=%0b, want 1000/0",
                  $signed(jointFreqCmd), ramping);
      end
   endtask

   task automatic test_ramp();
      int exp_out [6] = '{500, 400, 300, 200, 100, 50};
      bit exp_rmp [6] = '{1, 1, 1, 1, 1, 0};
      do_reset();
      enable = 1'b1;
      load(32'd50);
      for (int i = 0; i < 6; i++) begin
         wait_ticks(1);
         checks++;
         if ($signed(jointFreqCmd) !== exp_out[i] || ramping !== exp_rmp[i]) begin
            failures++;
            $display("FAIL ramp[%0d]: out=%0d ramping=%0b, want %0d/%0b",
                     i, $signed(jointFreqCmd), ramping, exp_out[i], exp_rmp[i]);
         end
      end
   endtask

   task automatic test_reverse();
      int exp_out [8] = '{0, 0, -500, -400, -300, -200, -100, -50};
      do_reset();
      enable = 1'b1;
      load(32'd50);
      wait_ticks(6);
      load(-32'sd50);
      for (int i = 0; i < 8; i++) begin
         wait_ticks(1);
         checks++;
         if ($signed(jointFreqCmd) !== exp_out[i]) begin
            failures++;
            $display("FAIL reverse[%0d]: out=%0d, want %0d", i, $signed(jointFreqCmd), exp_out[i]);
         end
      end
   endtask

   task automatic test_clamp();
      int exp_out [6] = '{500, 400, 300, 200, 100, 10};
      do_reset();
      enable = 1'b1;
      load(32'd3);
      for (int i = 0; i < 6; i++) begin
         wait_ticks(1);
         checks++;
         if ($signed(jointFreqCmd) !== exp_out[i]) begin
            failures++;
            $display("FAIL clamp_floor[%0d]: out=%0d, want %0d", i, $signed(jointFreqCmd), exp_out[i]);
         end
      end
      load(32'h8000_0000);
      wait_ticks(3);
      checks++;
      if (jointFreqCmd !== 32'h8000_0001 || ramping !== 1'b0) begin
         failures++;
         $display("FAIL saturate: out=%h ramping=%0b, want 80000001/0", jointFreqCmd, ramping);
      end
   endtask

   task automatic test_watchdog();
      do_reset();
      enable = 1'b1;
      load(32'd50);
      wait_ticks(WDT - 1);
      checks++;
      if (timeout !== 1'b0 || $signed(jointFreqCmd) !== 32'sd50) begin
         failures++;
         $display("FAIL wdt_pre: timeout=%0b out=%0d, want 0/50", timeout, $signed(jointFreqCmd));
      end
      wait_ticks(1);
      checks++;
      if (timeout !== 1'b1 || jointFreqCmd !== 32'd0 || ramping !== 1'b0) begin
         failures++;
         $display("FAIL wdt_fault: timeout=%0b out=%0d ramping=%0b, want 1/0/0",
                  timeout, $signed(jointFreqCmd), ramping);
      end
      load(32'd70);
      wait_ticks(2);
      checks++;
      if (timeout !== 1'b1 || jointFreqCmd !== 32'd0) begin
         failures++;
         $display("FAIL wdt_stay: timeout=%0b out=%0d, want 1/0", timeout, $signed(jointFreqCmd));
      end
      load(32'd0);
      checks++;
      if (timeout !== 1'b0) begin
         failures++;
         $display("FAIL wdt_exit: timeout=%0b, want 0", timeout);
      end
      load(32'd50);
      wait_ticks(1);
      checks++;
      if ($signed(jointFreqCmd) !== 32'sd500) begin
         failures++;
         $display("FAIL wdt_restart: out=%0d, want 500", $signed(jointFreqCmd));
      end
      // A load landing exactly on the expiry tick keeps the joint alive.
      do_reset();
      enable = 1'b1;
      load(32'd50);
      wait_ticks(WDT - 1);
      while (m_cnt != UD - 1) step();
      load(32'd50);
      wait_ticks(1);
      checks++;
      if (timeout !== 1'b0 || $signed(jointFreqCmd) !== 32'sd50) begin
         failures++;
         $display("FAIL wdt_load_wins: timeout=%0b out=%0d, want 0/50", timeout, $signed(jointFreqCmd));
      end
   endtask

   task automatic test_enable_reset();
      do_reset();
      enable = 1'b1;
      load(32'd300);
      wait_ticks(3);
      repeat (4) step();
      checks++;
      if ($signed(jointFreqCmd) !== 32'sd300) begin
         failures++;
         $display("FAIL en_pre: out=%0d, want 300", $signed(jointFreqCmd));
      end
      enable = 1'b0;
      step();
      checks++;
      if (jointFreqCmd !== 32'd0 || ramping !== 1'b0) begin
         failures++;
         $display("FAIL en_drop: out=%0d ramping=%0b, want 0/0", $signed(jointFreqCmd), ramping);
      end
      enable = 1'b1;
      load(32'd300);
      wait_ticks(1);
      step();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if (jointFreqCmd !== 32'd0 || timeout !== 1'b0 || ramping !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: out=%0d timeout=%0b ramping=%0b, want 0/0/0",
                  $signed(jointFreqCmd), timeout, ramping);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      step();
      checks++;
      if (jointFreqCmd !== 32'd0) begin
         failures++;
         $display("FAIL post_reset: out=%0d, want 0", $signed(jointFreqCmd));
      end
   endtask

   task automatic test_random();
      logic [31:0] v;
      int          r;
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            r = $urandom_range(1, 900);
            case ($urandom_range(0, 5))
               0: v = 32'd0;
               1: v = 32'h8000_0000;
               2: v = 32'($urandom_range(1, 2 * MINP));
               default: v = ($urandom_range(0, 1) == 1) ? -32'(r) : 32'(r);
            endcase
            cmdIn = v;
            cmdLoad = 1'b1;
         end
         if ($urandom_range(0, 199) == 0) enable = ~enable;
         step();
         cmdLoad = 1'b0;
         checks++;
         if (jointFreqCmd !== m_out[31:0] || timeout !== m_tmo || ramping !== m_ramp) begin
            failures++;
            $display("FAIL random[%0d]: out=%0d timeout=%0b ramping=%0b, want %0d/%0b/%0b",
                     i, $signed(jointFreqCmd), timeout, ramping, m_out, m_tmo, m_ramp);
         end
      end
      enable = 1'b1;
   endtask

   initial begin
      reset   = 1'b1;
      cmdIn   = 32'd0;
      cmdLoad = 1'b0;
      enable  = 1'b0;
      model_reset();
      test_reset();
      test_basic();
      test_ramp();
      test_reverse();
      test_clamp();
      test_watchdog();
      test_enable_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
